// File: rtl/display_scan.sv
// display_scan: captures BCD digits into a shadow buffer while the
// calculator is busy, commits them to the visible buffer when it becomes
// ready, and time-multiplexes the eight digits onto an active-low
// seven-segment display. An error status latches a sticky error flag and
// switches the display to an "Err o" pattern until reset.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros
// (digit 0 is always shown; the error pattern is never blanked).
`timescale 1ns/1ps

module display_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       frame_valid,
    output logic       err_flag
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] PRESCALE_LAST = CW'(SCAN_DIV - 1);

    localparam logic [1:0] ST_ERROR = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    logic [3:0]    shadow [8];
    logic [3:0]    disp   [8];
    logic          pending;
    logic [CW-1:0] prescale;
    logic [2:0]    scan_idx;
    logic          lz_blank;
    logic [6:0]    next_seg;

    // Seven-segment code (g..a, active low) for one BCD digit; non-BCD is blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    bcd_to_seg = 7'h40;
            4'd1:    bcd_to_seg = 7'h79;
            4'd2:    bcd_to_seg = 7'h24;
            4'd3:    bcd_to_seg = 7'h30;
            4'd4:    bcd_to_seg = 7'h19;
            4'd5:    bcd_to_seg = 7'h12;
            4'd6:    bcd_to_seg = 7'h02;
            4'd7:    bcd_to_seg = 7'h78;
            4'd8:    bcd_to_seg = 7'h00;
            4'd9:    bcd_to_seg = 7'h10;
            default: bcd_to_seg = 7'h7F;
        endcase
    endfunction

    // Error pattern reads "Erro" on digits 3..0 with the upper digits dark.
    function automatic logic [6:0] err_to_seg(input logic [2:0] idx);
        case (idx)
            3'd3:    err_to_seg = 7'h06;
            3'd2:    err_to_seg = 7'h2F;
            3'd1:    err_to_seg = 7'h2F;
            3'd0:    err_to_seg = 7'h23;
            default: err_to_seg = 7'h7F;
        endcase
    endfunction

    // Sticky error flag: any error status latches it until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_flag <= 1'b0;
        end else if (status == ST_ERROR) begin
            err_flag <= 1'b1;
        end
    end

    // Capture into shadow while busy, commit to disp when ready with a pending frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i[2:0]] <= 4'd0;
                disp[i[2:0]]   <= 4'd0;
            end
            pending     <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (!err_flag) begin
                if (status == ST_BUSY && !pos[3]) begin
                    shadow[pos[2:0]] <= data;
                    pending          <= 1'b1;
                end else if (status == ST_READY && pending) begin
                    for (int i = 0; i < 8; i++) begin
                        disp[i[2:0]] <= shadow[i[2:0]];
                    end
                    pending     <= 1'b0;
                    frame_valid <= 1'b1;
                end
            end
        end
    end

    // Prescaler sets the dwell time of each digit; scan_idx walks 0..7 and wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescale <= '0;
            scan_idx <= 3'd0;
        end else if (prescale == PRESCALE_LAST) begin
            prescale <= '0;
            scan_idx <= scan_idx + 3'd1;
        end else begin
            prescale <= prescale + CW'(1);
        end
    end

    // Leading-zero blanking: a digit above position 0 goes dark when it and every higher digit are zero.
    always_comb begin
        lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (scan_idx != 3'd0) begin
            lz_blank = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (i >= int'(scan_idx) && disp[i[2:0]] != 4'd0) begin
                    lz_blank = 1'b0;
                end
            end
        end
`endif
    end

    // Pick the segment pattern for the digit currently being scanned.
    always_comb begin
        next_seg = bcd_to_seg(disp[scan_idx]);
        if (err_flag) begin
            next_seg = err_to_seg(scan_idx);
        end else if (lz_blank) begin
            next_seg = 7'h7F;
        end
    end

    // Register the display drive so an and seg switch together without glitches.
    always_ff @(posedge clock) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= 8'hFF;
        end else begin
            an  <= ~(8'b0000_0001 << scan_idx);
            seg <= {1'b1, next_seg};
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: scoreboard bench for display_scan (SCAN_DIV = 4).
// A stimulus process drives inputs on the falling edge and pushes the
// expected post-edge outputs, computed by a buffer-level reference model,
// into a queue; a monitor pops and compares after every rising edge.
// Honours LEADING_ZERO_BLANK_EN the same way as the design.
`timescale 1ns/1ps

module tb_display_scan;

    localparam int DIV = 4;

    logic       clock;
    logic       reset;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an;
    logic [7:0] seg;
    logic       frame_valid;
    logic       err_flag;

    display_scan #(.SCAN_DIV(DIV)) dut (
        .clock       (clock),
        .reset       (reset),
        .status      (status),
        .data        (data),
        .pos         (pos),
        .an          (an),
        .seg         (seg),
        .frame_valid (frame_valid),
        .err_flag    (err_flag)
    );

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [7:0] seg;
        logic       fv;
        logic       err;
    } exp_t;

    exp_t expQ[$];

    int compared   = 0;
    int mismatched = 0;
    int cycNum     = 0;

    // Reference model state: buffers as plain arrays, scan position from elapsed cycles.
    logic [3:0] shadowM [8];
    logic [3:0] dispM   [8];
    bit         pendingM;
    bit         errM;
    int         sinceReset;
    int         frames;

    logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] errTable [8]  = '{7'h23, 7'h2F, 7'h2F, 7'h06, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    // Clock generation.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [6:0] digitCode(int i);
        int msd;
        if (errM) return errTable[i];
        msd = 0;
        for (int j = 0; j < 8; j++) if (dispM[j] != 4'd0) msd = j;
`ifdef LEADING_ZERO_BLANK_EN
        if (i > msd) return 7'h7F;
`endif
        return segTable[dispM[i]];
    endfunction

    // Drive one cycle of inputs, predict the outputs after the next edge, then advance the model.
    task automatic applyStimulus(input logic r, input logic [1:0] st,
                                 input logic [3:0] d, input logic [3:0] p);
        exp_t e;
        int   idx;
        @(negedge clock);
        reset  = r;
        status = st;
        data   = d;
        pos    = p;
        cycNum++;
        e.cyc = cycNum;
        if (r) begin
            e.an  = 8'hFF;
            e.seg = 8'hFF;
            e.fv  = 1'b0;
            e.err = 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadowM[i] = 4'd0;
                dispM[i]   = 4'd0;
            end
            pendingM   = 0;
            errM       = 0;
            sinceReset = 0;
        end else begin
            sinceReset++;
            idx   = ((sinceReset - 1) / DIV) % 8;
            e.an  = 8'hFF;
            e.an[idx] = 1'b0;
            e.seg = {1'b1, digitCode(idx)};
            e.fv  = !errM && st == 2'b10 && pendingM;
            e.err = errM || st == 2'b00;
            if (!errM) begin
                if (st == 2'b01 && p <= 4'd7) begin
                    shadowM[p] = d;
                    pendingM   = 1;
                end else if (st == 2'b10 && pendingM) begin
                    dispM    = shadowM;
                    pendingM = 0;
                    frames++;
                end
            end
            if (st == 2'b00) errM = 1;
        end
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        compared++;
        if (an !== e.an) begin
            mismatched++;
            $display("[TB] FAIL an cycle %0d: got %h expected %h", e.cyc, an, e.an);
        end
        compared++;
        if (seg !== e.seg) begin
            mismatched++;
            $display("[TB] FAIL seg cycle %0d: got %h expected %h", e.cyc, seg, e.seg);
        end
        compared++;
        if (frame_valid !== e.fv) begin
            mismatched++;
            $display("[TB] FAIL frame_valid cycle %0d: got %b expected %b", e.cyc, frame_valid, e.fv);
        end
        compared++;
        if (err_flag !== e.err) begin
            mismatched++;
            $display("[TB] FAIL err_flag cycle %0d: got %b expected %b", e.cyc, err_flag, e.err);
        end
    endtask

    // Monitor: after each rising edge, compare the DUT against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic doReset(int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 2'b10, 4'd0, 4'd0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b10, 4'd0, 4'd0);
    endtask

    // Directed scenarios first, then a randomized soak.
    initial begin
        logic [3:0] frameData [8] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        int r;
        logic [1:0] st;
        frames = 0;
        reset  = 1'b1;
        status = 2'b10;
        data   = 4'd0;
        pos    = 4'd0;

        $display("[TB] reset and idle scan");
        doReset(3);
        idle(40);

        $display("[TB] capture and commit 0123");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 2'b01, frameData[i], 4'(i));
        idle(1);
        idle(40);

        $display("[TB] out-of-range position");
        doReset(2);
        applyStimulus(1'b0, 2'b01, 4'd5, 4'd9);
        idle(36);

        $display("[TB] reset mid-capture");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b01, 4'(i + 5), 4'(i));
        doReset(1);
        idle(36);

        $display("[TB] error status");
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 2'b01, 4'(i + 1), 4'(i));
        idle(40);
        doReset(2);

        $display("[TB] random soak");
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 4) begin
                applyStimulus(1'b1, 2'(r), 4'($urandom), 4'($urandom));
            end else begin
                if (r < 7)        st = 2'b00;
                else if (r < 40)  st = 2'b11;
                else if (r < 600) st = 2'b01;
                else              st = 2'b10;
                if (errM && $urandom_range(0, 59) == 0) doReset(1);
                applyStimulus(1'b0, st, 4'($urandom), 4'($urandom_range(0, 9)));
            end
        end
        idle(4);

        @(posedge clock);
        #2;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("[TB] %0d frames committed by the model", frames);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit-scan step (legal range 2..2^20).
REQ-002 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port status  input  2  calculator status: 00 error, 01 busy, 10 ready.
REQ-005 SHALL have port data  input  4  BCD digit value presented for position pos.
REQ-006 SHALL have port pos  input  4  digit position 0..7; 0 is the least-significant digit.
REQ-007 SHALL have port an  output  8  active-low digit enables; bit i selects digit i.
REQ-008 SHALL have port seg  output  8  active-low segments; bits 6:0 = g..a, bit 7 = dp.
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when a new frame is committed.
REQ-010 SHALL have port err_flag  output  1  sticky indication that error status was seen.

Function
REQ-011 SHALL hold two 8x4-bit buffers: shadow (capture) and disp (shown).
REQ-012 SHALL write data into shadow[pos] on each cycle with status==01, err_flag==0 and pos<=7, then set pending.
REQ-013 SHALL ignore the write when pos>7, with no buffer change and no change to pending.
REQ-014 SHALL copy shadow into disp on a cycle with status==10 and pending==1, clear pending, and assert frame_valid in the next cycle only.
REQ-015 SHALL leave disp unchanged when status==10 and pending==0, and assert no frame_valid.
REQ-016 SHALL set err_flag on the cycle after any cycle with status==00; err_flag clears only on reset.
REQ-017 SHALL suspend capture and commit while err_flag==1.
REQ-018 SHALL count a prescaler 0..SCAN_DIV-1 with wrap; at SCAN_DIV-1 scan_idx SHALL advance 0->1->...->7->0.
REQ-019 SHALL register an and seg every cycle from the current scan_idx, giving one cycle of latency.
REQ-020 SHALL drive an = all ones except bit scan_idx = 0.
REQ-021 SHALL encode digits 0..9 on seg[6:0] as hex 40,79,24,30,19,12,02,78,00,10; values 10..15 SHALL be blank (7F).
REQ-022 SHALL hold seg[7] (dp) at 1, off, at all times.
REQ-023 SHALL show the error pattern while err_flag==1: digit3 E(06), digit2 r(2F), digit1 r(2F), digit0 o(23), digits 7..4 blank(7F).

Reset
REQ-024 SHALL clear shadow, disp, pending, err_flag, prescaler and scan_idx to 0 on a reset cycle.
REQ-025 SHALL drive an=FF, seg=FF and frame_valid=0 on the cycle after reset; normal scanning SHALL resume the cycle after reset deasserts.
REQ-026 SHALL discard any partially captured frame when reset asserts mid-capture; no frame_valid SHALL follow.

Configuration
REQ-027 SHALL blank leading zeros when macro LEADING_ZERO_BLANK_EN is defined: digit i>0 shows 7F if disp[7..i] are all 0, and digit 0 is always shown.
REQ-028 SHALL show all eight digits, including leading zeros, when LEADING_ZERO_BLANK_EN is undefined.
REQ-029 SHALL NOT apply leading-zero blanking to the error pattern.

Verification (SCAN_DIV=4)
REQ-030 Reset, then idle for 40 cycles -> scan_idx steps every 4 cycles; an cycles FE,FD,...,7F,FE; seg=40 each digit (macro off); frame_valid never asserts.
REQ-031 Busy with pos 0..7, data 3,2,1,0,0,0,0,0, then status=10 -> a single frame_valid pulse; digits 0..2 show 30,24,79; digits 3..7 show 40 (macro off) or 7F (macro on).
REQ-032 Status=10 held for 20 cycles after a commit -> no further frame_valid pulse and disp unchanged.
REQ-033 Busy with pos=9, data=5 -> shadow unchanged and pending stays 0; a following status=10 produces no frame_valid.
REQ-034 Status=00 for one cycle, then busy writes and status=10 -> err_flag=1 from the next cycle; digits 3..0 show 06,2F,2F,23; no frame_valid; persists until reset.
REQ-035 Reset asserted mid-capture at pos=4, then status=10 -> no frame_valid; all buffers 0; an=FF and seg=FF on the cycle after reset.
